// File: rtl/pulse_sequencer.sv
// Pulse frame sequencer: pre-delay, two pulse trains, main pulse and tail, with exact cycle counts.
// Parameters are shadowed at frame start; optional free-running continuous mode.
module pulse_sequencer #(
    parameter int BIT_WIDTH  = 10,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  cont,
    input  logic [BIT_WIDTH-1:0]  D,
    input  logic [BIT_WIDTH-1:0]  B1,
    input  logic [BIT_WIDTH-1:0]  C1,
    input  logic [BIT_WIDTH-1:0]  D1,
    input  logic [BIT_WIDTH-1:0]  B2,
    input  logic [BIT_WIDTH-1:0]  C2,
    input  logic [BIT_WIDTH-1:0]  D2,
    input  logic [BIT_WIDTH-1:0]  B,
    input  logic [BIT_WIDTH-1:0]  C,
    input  logic [BIT_WIDTH-1:0]  E,
    input  logic [BIT_WIDTH-1:0]  n1,
    input  logic [BIT_WIDTH-1:0]  n2,
    output logic                  pulse_out,
    output logic                  busy,
    output logic                  done,
    output logic [FCNT_WIDTH-1:0] frame_cnt,
    output logic [3:0]            state_dbg
);

    // state  | meaning
    // IDLE   | waiting for start (or an immediate rerun of an empty continuous frame)
    // PRE    | pre-delay, low
    // T1_HI  | train 1 high phase
    // T1_LO  | train 1 low phase
    // GAP1   | gap after train 1, low
    // T2_HI  | train 2 high phase
    // T2_LO  | train 2 low phase
    // GAP2   | gap after train 2, low
    // M_HI   | main pulse, high
    // M_LO   | after main pulse, low
    // TAIL   | tail, low
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        PRE   = 4'd1,
        T1_HI = 4'd2,
        T1_LO = 4'd3,
        GAP1  = 4'd4,
        T2_HI = 4'd5,
        T2_LO = 4'd6,
        GAP2  = 4'd7,
        M_HI  = 4'd8,
        M_LO  = 4'd9,
        TAIL  = 4'd10
    } state_t;

    typedef struct packed {
        logic [BIT_WIDTH-1:0] d, b1, c1, d1, b2, c2, d2, b, c, e, n1, n2;
    } prm_t;

    typedef struct packed {
        state_t               st;
        logic [BIT_WIDTH-1:0] rep;
    } seg_t;

    localparam logic [BIT_WIDTH-1:0] ONE = {{(BIT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state;
    prm_t                 shadow;
    prm_t                 prm_in;
    logic [BIT_WIDTH-1:0] cnt;
    logic [BIT_WIDTH-1:0] rep;
    logic                 rerun;
    seg_t                 nx_run;
    seg_t                 nx_new;
    logic [BIT_WIDTH-1:0] run_len;
    logic [BIT_WIDTH-1:0] new_len;

    function automatic logic [BIT_WIDTH-1:0] seg_len(state_t s, prm_t p);
        logic [BIT_WIDTH-1:0] len;
        len = '0;
        case (s)
            PRE:     len = p.d;
            T1_HI:   len = p.b1;
            T1_LO:   len = p.c1;
            GAP1:    len = p.d1;
            T2_HI:   len = p.b2;
            T2_LO:   len = p.c2;
            GAP2:    len = p.d2;
            M_HI:    len = p.b;
            M_LO:    len = p.c;
            TAIL:    len = p.e;
            default: len = '0;
        endcase
        return len;
    endfunction

    function automatic logic is_hi(state_t s);
        return (s == T1_HI) || (s == T2_HI) || (s == M_HI);
    endfunction

    // Walk forward past zero-length segments; a train whose high and low are both
    // empty is skipped whole so the walk stays bounded regardless of the repeat count.
    function automatic seg_t advance(state_t s_in, logic [BIT_WIDTH-1:0] r_in, prm_t p);
        state_t               s;
        logic [BIT_WIDTH-1:0] r;
        logic                 stop;
        s    = s_in;
        r    = r_in;
        stop = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!stop) begin
                case (s)
                    IDLE:  s = PRE;
                    PRE: begin
                        if (p.n1 != '0 && (p.b1 != '0 || p.c1 != '0)) begin
                            s = T1_HI;
                            r = p.n1;
                        end else begin
                            s = GAP1;
                        end
                    end
                    T1_HI: s = T1_LO;
                    T1_LO: begin
                        if (r > ONE) begin
                            r = r - ONE;
                            s = T1_HI;
                        end else begin
                            s = GAP1;
                        end
                    end
                    GAP1: begin
                        if (p.n2 != '0 && (p.b2 != '0 || p.c2 != '0)) begin
                            s = T2_HI;
                            r = p.n2;
                        end else begin
                            s = GAP2;
                        end
                    end
                    T2_HI: s = T2_LO;
                    T2_LO: begin
                        if (r > ONE) begin
                            r = r - ONE;
                            s = T2_HI;
                        end else begin
                            s = GAP2;
                        end
                    end
                    GAP2:    s = M_HI;
                    M_HI:    s = M_LO;
                    M_LO:    s = TAIL;
                    default: s = IDLE;
                endcase
                if (s == IDLE || seg_len(s, p) != '0) stop = 1'b1;
            end
        end
        return '{st: s, rep: r};
    endfunction

    assign prm_in = {D, B1, C1, D1, B2, C2, D2, B, C, E, n1, n2};

    always_comb begin
        nx_run  = advance(state, rep, shadow);
        nx_new  = advance(IDLE, '0, prm_in);
        run_len = seg_len(nx_run.st, shadow);
        new_len = seg_len(nx_new.st, prm_in);
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shadow    <= '0;
            cnt       <= '0;
            rep       <= '0;
            rerun     <= 1'b0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                cnt       <= '0;
                rerun     <= 1'b0;
                pulse_out <= 1'b0;
                busy      <= 1'b0;
            end else if (state == IDLE) begin
                pulse_out <= 1'b0;
                if (start || rerun) begin
                    shadow <= prm_in;
                    if (nx_new.st == IDLE) begin
                        done      <= 1'b1;
                        frame_cnt <= frame_cnt + 1'b1;
                        rerun     <= cont;
                        busy      <= 1'b0;
                    end else begin
                        state     <= nx_new.st;
                        rep       <= nx_new.rep;
                        cnt       <= new_len;
                        pulse_out <= is_hi(nx_new.st);
                        busy      <= 1'b1;
                        rerun     <= 1'b0;
                    end
                end
            end else if (state > TAIL) begin
                state     <= IDLE;
                pulse_out <= 1'b0;
                busy      <= 1'b0;
            end else if (cnt > ONE) begin
                cnt <= cnt - ONE;
            end else if (nx_run.st != IDLE) begin
                state     <= nx_run.st;
                rep       <= nx_run.rep;
                cnt       <= run_len;
                pulse_out <= is_hi(nx_run.st);
            end else begin
                done      <= 1'b1;
                frame_cnt <= frame_cnt + 1'b1;
                if (cont && nx_new.st != IDLE) begin
                    shadow    <= prm_in;
                    state     <= nx_new.st;
                    rep       <= nx_new.rep;
                    cnt       <= new_len;
                    pulse_out <= is_hi(nx_new.st);
                end else begin
                    // An empty follow-on frame completes from IDLE on the next cycle.
                    state     <= IDLE;
                    pulse_out <= 1'b0;
                    busy      <= 1'b0;
                    rerun     <= cont;
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench for pulse_sequencer: a frame-level model queues expected pulse bits,
// frame lengths and frame counts; a negedge monitor checks them as the DUT emits them.
module tb_pulse_sequencer;
    localparam int BW = 10;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cont = 1'b0;
    logic [BW-1:0] prm [12];
    logic          pulse_out, busy, done;
    logic [FW-1:0] frame_cnt;
    logic [3:0]    state_dbg;

    // prm index: 0 D, 1 B1, 2 C1, 3 D1, 4 B2, 5 C2, 6 D2, 7 B, 8 C, 9 E, 10 n1, 11 n2
    pulse_sequencer #(.BIT_WIDTH(BW), .FCNT_WIDTH(FW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont(cont),
        .D(prm[0]), .B1(prm[1]), .C1(prm[2]), .D1(prm[3]), .B2(prm[4]), .C2(prm[5]),
        .D2(prm[6]), .B(prm[7]), .C(prm[8]), .E(prm[9]), .n1(prm[10]), .n2(prm[11]),
        .pulse_out(pulse_out), .busy(busy), .done(done), .frame_cnt(frame_cnt),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    bit   exp_pulse[$];
    int   exp_len[$];
    int   exp_fcnt[$];
    int   model_fcnt = 0;
    int   consumed = 0;
    logic prev_busy = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_run(input bit level, input int len);
        for (int i = 0; i < len; i++) exp_pulse.push_back(level);
    endtask

    // Expected frame straight from the segment rules, using the current inputs.
    task automatic model_push();
        int p[12];
        int len;
        for (int i = 0; i < 12; i++) p[i] = int'(prm[i]);
        push_run(1'b0, p[0]);
        for (int r = 0; r < p[10]; r++) begin
            push_run(1'b1, p[1]);
            push_run(1'b0, p[2]);
        end
        push_run(1'b0, p[3]);
        for (int r = 0; r < p[11]; r++) begin
            push_run(1'b1, p[4]);
            push_run(1'b0, p[5]);
        end
        push_run(1'b0, p[6]);
        push_run(1'b1, p[7]);
        push_run(1'b0, p[8]);
        push_run(1'b0, p[9]);
        len = p[0] + p[10] * (p[1] + p[2]) + p[3] + p[11] * (p[4] + p[5]) + p[6] + p[7] + p[8] + p[9];
        exp_len.push_back(len);
        model_fcnt = (model_fcnt + 1) % (1 << FW);
        exp_fcnt.push_back(model_fcnt);
    endtask

    task automatic flush();
        exp_pulse.delete();
        exp_len.delete();
        exp_fcnt.delete();
        consumed = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (exp_len.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    int l;
                    l = exp_len.pop_front();
                    check("frame_len", consumed, l);
                    check("done_after_busy", prev_busy, (l > 0));
                    check("frame_cnt", frame_cnt, exp_fcnt.pop_front());
                end
                consumed = 0;
            end
            if (busy) begin
                if (exp_pulse.size() == 0) check("extra_busy_cycle", busy, 0);
                else check("pulse_out", pulse_out, exp_pulse.pop_front());
                consumed++;
            end else begin
                check("idle_pulse", pulse_out, 0);
            end
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_prm(input int v[12]);
        for (int i = 0; i < 12; i++) prm[i] = BW'(v[i]);
    endtask

    task automatic rand_prm();
        for (int i = 0; i < 12; i++) prm[i] = BW'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) prm[10] = BW'($urandom_range(0, 6));
        if ($urandom_range(0, 7) == 0) for (int i = 0; i < 12; i++) prm[i] = '0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            tick();
            n++;
        end
        if (!done) check(name, done, 1);
    endtask

    task automatic wait_state(input logic [3:0] s, input string name);
        int n;
        n = 0;
        while (state_dbg != s && n < 3000) begin
            tick();
            n++;
        end
        if (state_dbg != s) check(name, state_dbg, s);
    endtask

    task automatic run_frame(input bit extra_start);
        model_push();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (extra_start && busy) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_done("done_timeout");
        tick();
    endtask

    task automatic run_cont(input int n);
        int d, c;
        for (int i = 0; i < n; i++) model_push();
        cont  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        d = 0;
        c = 0;
        while (d < n && c < 5000) begin
            if (done) begin
                d++;
                if (d == n - 1) cont = 1'b0;
            end
            if (d < n) begin
                tick();
                c++;
            end
        end
        if (d < n) check("cont_timeout", d, n);
        cont = 1'b0;
        tick();
        tick();
        check("cont_idle_state", state_dbg, 0);
        check("cont_idle_busy", busy, 0);
    endtask

    initial begin
        int f0;
        for (int i = 0; i < 12; i++) prm[i] = '0;
        tick();
        tick();
        check("rst_pulse", pulse_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fcnt", frame_cnt, 0);
        check("rst_state", state_dbg, 0);
        rst_n = 1'b1;
        tick();

        // basic frame: 0,0,1,0,1,0,1,1,1,0
        set_prm('{2, 1, 1, 0, 0, 0, 0, 3, 0, 1, 2, 0});
        run_frame(1'b0);

        // all-zero frame completes immediately without busy
        set_prm('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        run_frame(1'b0);

        // continuous: 1,1,0,0 three times
        set_prm('{0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0});
        run_cont(3);

        // shadowing: B changes at t+2 but the frame keeps B=5
        set_prm('{0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0});
        model_push();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        prm[7] = BW'(1);
        wait_done("shadow_timeout");
        tick();

        // abort during M_HI
        set_prm('{1, 1, 1, 1, 0, 0, 0, 4, 2, 1, 2, 0});
        f0 = model_fcnt;
        model_push();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_state(4'd8, "wait_m_hi");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_pulse", pulse_out, 0);
        check("abort_state", state_dbg, 0);
        check("abort_busy", busy, 0);
        flush();
        model_fcnt = f0;
        repeat (4) tick();
        check("abort_fcnt", frame_cnt, f0);

        // start with abort in IDLE: no frame
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("collide_busy", busy, 0);
        check("collide_done", done, 0);
        tick();
        check("collide_state", state_dbg, 0);
        check("collide_fcnt", frame_cnt, f0);

        // asynchronous reset during T2_HI
        set_prm('{1, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0, 2});
        model_push();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_state(4'd5, "wait_t2_hi");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pulse", pulse_out, 0);
        check("arst_busy", busy, 0);
        check("arst_fcnt", frame_cnt, 0);
        check("arst_state", state_dbg, 0);
        flush();
        model_fcnt = 0;
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        set_prm('{2, 1, 1, 0, 0, 0, 0, 3, 0, 1, 2, 0});
        run_frame(1'b0);

        // randomized frames, some with a stray start mid-frame
        for (int k = 0; k < 40; k++) begin
            rand_prm();
            run_frame($urandom_range(0, 1) == 1);
        end
        for (int k = 0; k < 3; k++) begin
            rand_prm();
            if (prm[7] == '0) prm[7] = BW'(1);
            run_cont(int'($urandom_range(2, 4)));
        end

        repeat (5) tick();
        check("leftover_pulses", exp_pulse.size(), 0);
        check("leftover_frames", exp_len.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
